// File: rtl/status_msg_tx.sv
// status_msg_tx: turns fault / drop / node events into fixed 8-byte ASCII
// status frames ("FIM-NN-#", "BDM-NN-#", "NOD-NN-#") and feeds them one
// byte at a time to a UART transmitter using a tx_start / tx_busy handshake.
//
// Parameters:
//   MSG_LEN       bytes per frame (fixed at 8)
//   BUSY_TIMEOUT  cycles to wait for tx_busy to rise before abandoning a byte
// Ports:
//   clk_50M       system clock, rising edge
//   reset         asynchronous active-high reset
//   fault_detect  fault level; each 0->1 transition is one fault event
//   object_drop   one-cycle drop event pulse
//   node_changed  one-cycle node event pulse
//   realtime_pos  current node index 0-31, captured with each event
//   tx_busy       UART transmitter busy
//   tx_data       byte presented to the UART
//   tx_start      one-cycle transmit request
//   msg_pending   an event is latched or a frame is in flight
//   overrun       sticky: an event or a byte was lost
// Build option:
//   STATUS_MSG_NODE_EN  when defined, node events are latched and sent;
//                       otherwise node_changed is ignored entirely.
`timescale 1ns/1ps

module status_msg_tx #(
  parameter int unsigned MSG_LEN      = 8,
  parameter logic [15:0] BUSY_TIMEOUT = 16'd5000
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       fault_detect,
  input  logic       object_drop,
  input  logic       node_changed,
  input  logic [4:0] realtime_pos,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       msg_pending,
  output logic       overrun
);

  localparam logic [2:0] LAST_IDX = 3'(MSG_LEN - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, NEXT} state_t;
  typedef enum logic [1:0] {MSG_FIM, MSG_BDM, MSG_NOD} msg_t;

  state_t      state_q, state_d;
  msg_t        sel_q, sel_d, frm_type_q, frm_type_d;
  logic [4:0]  frm_pos_q, frm_pos_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic        overrun_q, overrun_d;
  logic        fault_prev_q, fault_prev_d;
  logic        fault_armed_q, fault_armed_d;
  logic        fault_full_q, fault_full_d, drop_full_q, drop_full_d;
  logic [4:0]  fault_pos_q, fault_pos_d, drop_pos_q, drop_pos_d;
  logic        node_full;
  logic [4:0]  node_pos;
  logic        fault_ev;
  logic [4:0]  sel_pos;

`ifdef STATUS_MSG_NODE_EN
  logic        node_full_q, node_full_d;
  logic [4:0]  node_pos_q, node_pos_d;
  assign node_full = node_full_q;
  assign node_pos  = node_pos_q;
`else
  logic unused_node;
  assign unused_node = node_changed;
  assign node_full   = 1'b0;
  assign node_pos    = '0;
`endif

  // Fault edges only count once the input has been seen low since reset,
  // so a level already high at reset release does not produce an event.
  assign fault_ev = fault_detect & ~fault_prev_q & fault_armed_q;

  function automatic logic [7:0] frame_byte(input msg_t t, input logic [4:0] pos,
                                            input logic [2:0] i);
    logic [1:0] tens;
    logic [4:0] units;
    logic [7:0] b;
    if (pos >= 5'd30)      begin tens = 2'd3; units = pos - 5'd30; end
    else if (pos >= 5'd20) begin tens = 2'd2; units = pos - 5'd20; end
    else if (pos >= 5'd10) begin tens = 2'd1; units = pos - 5'd10; end
    else                   begin tens = 2'd0; units = pos;         end
    case (i)
      3'd0:    b = (t == MSG_FIM) ? "F" : (t == MSG_BDM) ? "B" : "N";
      3'd1:    b = (t == MSG_FIM) ? "I" : (t == MSG_BDM) ? "D" : "O";
      3'd2:    b = (t == MSG_NOD) ? "D" : "M";
      3'd4:    b = 8'h30 + {6'd0, tens};
      3'd5:    b = 8'h30 + {3'd0, units};
      3'd7:    b = "#";
      default: b = "-";
    endcase
    return b;
  endfunction

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    frm_type_d    = frm_type_q;
    frm_pos_d     = frm_pos_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    overrun_d     = overrun_q;
    fault_prev_d  = fault_detect;
    fault_armed_d = fault_armed_q | ~fault_detect;

    case (sel_q)
      MSG_FIM: sel_pos = fault_pos_q;
      MSG_BDM: sel_pos = drop_pos_q;
      default: sel_pos = node_pos;
    endcase

    // Pending latches: the granted latch empties in LOAD, and an event in
    // that same cycle refills it rather than counting as an overrun.
    fault_full_d = fault_full_q & ~(state_q == LOAD && sel_q == MSG_FIM);
    fault_pos_d  = fault_pos_q;
    if (fault_ev) begin
      if (fault_full_d) overrun_d = 1'b1;
      else begin fault_full_d = 1'b1; fault_pos_d = realtime_pos; end
    end

    drop_full_d = drop_full_q & ~(state_q == LOAD && sel_q == MSG_BDM);
    drop_pos_d  = drop_pos_q;
    if (object_drop) begin
      if (drop_full_d) overrun_d = 1'b1;
      else begin drop_full_d = 1'b1; drop_pos_d = realtime_pos; end
    end

`ifdef STATUS_MSG_NODE_EN
    node_full_d = node_full_q & ~(state_q == LOAD && sel_q == MSG_NOD);
    node_pos_d  = node_pos_q;
    if (node_changed) begin
      if (node_full_d) overrun_d = 1'b1;
      else begin node_full_d = 1'b1; node_pos_d = realtime_pos; end
    end
`endif

    case (state_q)
      IDLE: begin
        if (fault_full_q)      begin sel_d = MSG_FIM; state_d = LOAD; end
        else if (drop_full_q)  begin sel_d = MSG_BDM; state_d = LOAD; end
        else if (node_full)    begin sel_d = MSG_NOD; state_d = LOAD; end
      end
      LOAD: begin
        frm_type_d = sel_q;
        frm_pos_d  = sel_pos;
        idx_d      = '0;
        tx_data_d  = frame_byte(sel_q, sel_pos, 3'd0);
        state_d    = START;
      end
      START: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          cnt_d      = '0;
          state_d    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) state_d = WAIT_DONE;
        else if (cnt_q == BUSY_TIMEOUT - 16'd1) begin
          overrun_d = 1'b1;
          state_d   = NEXT;
        end else cnt_d = cnt_q + 16'd1;
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = NEXT;
      end
      NEXT: begin
        if (idx_q == LAST_IDX) state_d = IDLE;
        else begin
          idx_d     = idx_q + 3'd1;
          tx_data_d = frame_byte(frm_type_q, frm_pos_q, idx_q + 3'd1);
          state_d   = START;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      sel_q         <= MSG_FIM;
      frm_type_q    <= MSG_FIM;
      frm_pos_q     <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      overrun_q     <= 1'b0;
      fault_prev_q  <= 1'b0;
      fault_armed_q <= 1'b0;
      fault_full_q  <= 1'b0;
      fault_pos_q   <= '0;
      drop_full_q   <= 1'b0;
      drop_pos_q    <= '0;
`ifdef STATUS_MSG_NODE_EN
      node_full_q   <= 1'b0;
      node_pos_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      frm_type_q    <= frm_type_d;
      frm_pos_q     <= frm_pos_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      overrun_q     <= overrun_d;
      fault_prev_q  <= fault_prev_d;
      fault_armed_q <= fault_armed_d;
      fault_full_q  <= fault_full_d;
      fault_pos_q   <= fault_pos_d;
      drop_full_q   <= drop_full_d;
      drop_pos_q    <= drop_pos_d;
`ifdef STATUS_MSG_NODE_EN
      node_full_q   <= node_full_d;
      node_pos_q    <= node_pos_d;
`endif
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign overrun     = overrun_q;
  assign msg_pending = fault_full_q | drop_full_q | node_full | (state_q != IDLE);

endmodule

// File: tb/tb_status_msg_tx.sv
// Testbench for status_msg_tx: expected frame bytes are queued when events
// are issued; a monitor pops one per tx_start and compares tx_data.
`timescale 1ns/1ps

module tb_status_msg_tx;

  logic       clk_50M = 1'b0;
  logic       reset;
  logic       fault_detect, object_drop, node_changed;
  logic [4:0] realtime_pos;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start, msg_pending, overrun;

  logic       uart_en;
  int         busy_cnt;
  int         n_cmp = 0;
  int         n_err = 0;
  int         start_cnt = 0;
  logic [7:0] exp_q[$];

  status_msg_tx dut (
    .clk_50M      (clk_50M),
    .reset        (reset),
    .fault_detect (fault_detect),
    .object_drop  (object_drop),
    .node_changed (node_changed),
    .realtime_pos (realtime_pos),
    .tx_busy      (tx_busy),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .msg_pending  (msg_pending),
    .overrun      (overrun)
  );

  always #10 clk_50M = ~clk_50M;

  // UART model: busy for 10 cycles per accepted byte; uart_en=0 models a
  // transmitter that never responds.
  always @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      tx_busy  <= 1'b0;
      busy_cnt <= 0;
    end else if (tx_busy) begin
      if (busy_cnt == 1) tx_busy <= 1'b0;
      busy_cnt <= busy_cnt - 1;
    end else if (tx_start && uart_en) begin
      tx_busy  <= 1'b1;
      busy_cnt <= 10;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_msg(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic wait_idle(input string name, input int max);
    int k = 0;
    while (msg_pending !== 1'b0 && k < max) begin
      @(negedge clk_50M);
      k++;
    end
    check(name, {31'd0, msg_pending}, 32'd0);
  endtask

  task automatic wait_starts(input string name, input int target, input int max);
    int k = 0;
    while (start_cnt < target && k < max) begin
      @(negedge clk_50M);
      k++;
    end
    check(name, start_cnt, target);
  endtask

  // Monitor: every tx_start must carry the next expected byte.
  initial forever begin
    @(negedge clk_50M);
    if (reset === 1'b0 && tx_start === 1'b1) begin
      start_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_tx_start: got byte %0h, required no transmission", tx_data);
      end else begin
        check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #(70000 * 20);
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int hi;
    reset = 1'b1; fault_detect = 1'b0; object_drop = 1'b0; node_changed = 1'b0;
    realtime_pos = '0; uart_en = 1'b1;
    cycles(3);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_pending", {31'd0, msg_pending}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    cycles(3);

    // Single node event at pos 5 (or ignored when node support is absent)
    base = start_cnt;
`ifdef STATUS_MSG_NODE_EN
    push_msg("NOD-05-#");
    realtime_pos = 5'd5; node_changed = 1'b1; cycles(1); node_changed = 1'b0;
    cycles(2);
    wait_idle("A_idle", 500);
    check("A_starts", start_cnt - base, 32'd8);
`else
    realtime_pos = 5'd5; node_changed = 1'b1; cycles(1); node_changed = 1'b0;
    hi = 0;
    repeat (40) begin
      @(negedge clk_50M);
      if (msg_pending !== 1'b0) hi++;
    end
    check("A_nonode_pending_cycles", hi, 32'd0);
    check("A_nonode_starts", start_cnt - base, 32'd0);
`endif

    // All three events in one cycle; fault level then held high
    base = start_cnt;
    push_msg("FIM-12-#");
    push_msg("BDM-12-#");
`ifdef STATUS_MSG_NODE_EN
    push_msg("NOD-12-#");
`endif
    realtime_pos = 5'd12; fault_detect = 1'b1; object_drop = 1'b1; node_changed = 1'b1;
    cycles(1);
    object_drop = 1'b0; node_changed = 1'b0;
    cycles(2);
    wait_idle("B_idle", 1500);
`ifdef STATUS_MSG_NODE_EN
    check("B_starts", start_cnt - base, 32'd24);
`else
    check("B_starts", start_cnt - base, 32'd16);
`endif
    check("B_overrun", {31'd0, overrun}, 32'd0);
    cycles(20);
    check("B_held_fault_pending", {31'd0, msg_pending}, 32'd0);

    // Two drops while a fault frame is sending: second is lost
    fault_detect = 1'b0; cycles(2);
    base = start_cnt;
    push_msg("FIM-07-#");
    push_msg("BDM-03-#");
    realtime_pos = 5'd7; fault_detect = 1'b1; cycles(1);
    wait_starts("C_first_start", base + 1, 100);
    realtime_pos = 5'd3; object_drop = 1'b1; cycles(1); object_drop = 1'b0;
    cycles(5);
    realtime_pos = 5'd4; object_drop = 1'b1; cycles(1); object_drop = 1'b0;
    check("C_overrun_set", {31'd0, overrun}, 32'd1);
    wait_idle("C_idle", 1000);
    check("C_starts", start_cnt - base, 32'd16);
    check("C_overrun_sticky", {31'd0, overrun}, 32'd1);

    // Reset during byte index 4; fault stays high across release
    fault_detect = 1'b0; cycles(2);
    base = start_cnt;
    push_msg("FIM-2");
    realtime_pos = 5'd20; fault_detect = 1'b1; cycles(1);
    wait_starts("D_five_starts", base + 5, 200);
    cycles(2);
    reset = 1'b1;
    cycles(1);
    check("D_rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("D_rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("D_rst_pending", {31'd0, msg_pending}, 32'd0);
    check("D_rst_overrun", {31'd0, overrun}, 32'd0);
    cycles(2);
    reset = 1'b0;
    base = start_cnt;
    cycles(200);
    check("D_no_resume", start_cnt - base, 32'd0);
    check("D_pending_after", {31'd0, msg_pending}, 32'd0);

    // Position boundaries 31 / 0 / 19 and fault re-arm after release
    fault_detect = 1'b0; cycles(2);
    base = start_cnt;
    push_msg("FIM-31-#");
    push_msg("BDM-00-#");
`ifdef STATUS_MSG_NODE_EN
    push_msg("NOD-19-#");
`endif
    realtime_pos = 5'd31; fault_detect = 1'b1; cycles(1);
    realtime_pos = 5'd0; object_drop = 1'b1; cycles(1); object_drop = 1'b0;
`ifdef STATUS_MSG_NODE_EN
    realtime_pos = 5'd19; node_changed = 1'b1; cycles(1); node_changed = 1'b0;
`endif
    cycles(2);
    wait_idle("E_idle", 1500);
`ifdef STATUS_MSG_NODE_EN
    check("E_starts", start_cnt - base, 32'd24);
`else
    check("E_starts", start_cnt - base, 32'd16);
`endif
    check("E_overrun", {31'd0, overrun}, 32'd0);

    // Transmitter never goes busy: every byte times out
    uart_en = 1'b0;
    base = start_cnt;
    push_msg("BDM-09-#");
    realtime_pos = 5'd9; object_drop = 1'b1; cycles(1); object_drop = 1'b0;
    cycles(2);
    wait_idle("F_idle", 45000);
    check("F_starts", start_cnt - base, 32'd8);
    check("F_overrun", {31'd0, overrun}, 32'd1);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/status_msg_tx.md
STATUS_MSG_TX -- requirements
Module: status_msg_tx

Interface
REQ-001 Parameter: MSG_LEN, default 8, bytes per message (fixed frame; changing it is illegal).
REQ-002 Parameter: BUSY_TIMEOUT, default 16'd5000, clk_50M cycles to wait for tx_busy to rise before abandoning a byte.
REQ-003 clk_50M  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 fault_detect  input  1  level from fault detection; its rising edge is a fault event.
REQ-006 object_drop  input  1  one-cycle pulse; a drop event.
REQ-007 node_changed  input  1  one-cycle pulse; a node event.
REQ-008 realtime_pos  input  5  current node index, 0-31; sampled at each event.
REQ-009 tx_busy  input  1  high while the UART transmitter shifts a byte.
REQ-010 tx_data  output  8  ASCII byte presented to the UART transmitter.
REQ-011 tx_start  output  1  one-cycle pulse requesting transmission of tx_data.
REQ-012 msg_pending  output  1  high while any event is latched or a message is in flight.
REQ-013 overrun  output  1  sticky flag; set when an event is lost.

Function
REQ-014 Message frames SHALL be 8 bytes: fault "FIM-NN-#", drop "BDM-NN-#", node "NOD-NN-#"; NN is the 2-digit decimal ASCII of the captured position, zero-padded (5 -> "05", 31 -> "31").
REQ-015 Decimal split: tens = 3/2/1/0 by thresholds 30/20/10; units = pos - 10*tens; no divider.
REQ-016 Each event type SHALL have a one-deep pending latch holding a 5-bit position captured in the cycle the event is seen.
REQ-017 The fault event SHALL be the 0->1 transition of fault_detect registered once; a held-high level produces exactly one event.
REQ-018 An event arriving while its own latch is full SHALL be discarded, the stored position kept, and overrun set.
REQ-019 Events of different types in the same cycle SHALL all be latched.
REQ-020 Arbitration SHALL occur only in IDLE, fixed priority fault > drop > node; the granted latch clears on the LOAD cycle and may be refilled immediately.
REQ-021 FSM states: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, NEXT.
REQ-022 IDLE -> LOAD when any latch is full; LOAD copies type and position into a frame register, index := 0.
REQ-023 START: drive tx_data = byte[index] and pulse tx_start for exactly one cycle only if tx_busy is low; else hold in START.
REQ-024 WAIT_BUSY: wait for tx_busy = 1, then WAIT_DONE; if BUSY_TIMEOUT cycles elapse without it, go to NEXT (byte abandoned, overrun set).
REQ-025 WAIT_DONE: wait for tx_busy = 0, then NEXT.
REQ-026 NEXT: if index = 7 go IDLE, else index+1 and go START.
REQ-027 tx_data SHALL remain stable from START through WAIT_DONE.
REQ-028 Minimum spacing between tx_start pulses: 3 cycles plus the busy period.
REQ-029 msg_pending = any latch full OR state != IDLE.
REQ-030 overrun SHALL clear only on reset.

Reset
REQ-031 While reset is high: state IDLE, all latches empty, index 0, tx_data 8'h00, tx_start 0, msg_pending 0, overrun 0, fault edge register 0.
REQ-032 Reset asserted mid-message SHALL abort the frame immediately; no partial resume after release.
REQ-033 If fault_detect is high on reset release, no fault event SHALL be generated until it falls and rises again.

Configuration
REQ-034 Macro STATUS_MSG_NODE_EN: defined -> node events latched and sent as "NOD-NN-#"; undefined -> node_changed ignored, node latch and frame logic absent, only fault and drop messages sent.

Verification
REQ-035 node_changed pulse, pos=5, UART model busy 10 cycles/byte -> bytes "NOD-05-#" in order, 8 tx_start pulses, msg_pending low afterwards.
REQ-036 fault rise, object_drop, node_changed in same cycle, pos=12 -> "FIM-12-#", "BDM-12-#", "NOD-12-#" sequence; overrun stays 0.
REQ-037 Two drop pulses at pos 3 and 4 while a fault frame is sending -> one "BDM-03-#" sent, overrun = 1.
REQ-038 tx_busy never rises -> after 5000 cycles each byte abandoned, FSM returns to IDLE after 8 timeouts, overrun = 1.
REQ-039 Reset asserted at byte index 4 -> tx_start stops, outputs at reset values, no further bytes after release.
REQ-040 Build without STATUS_MSG_NODE_EN, pulse node_changed -> no tx_start, msg_pending stays 0.
